retire_stage: RTL

- Terminal consumer of the address pipeline; sits directly downstream of the last pipeline_stage and takes its out_address/out_id/out_valid each unstalled cycle.
- Checks each retiring address against a protected window. A hit is dropped and generates a flush request back into the flush chain. Passing entries are buffered in a FIFO and drained to the consumer over a valid/ready handshake.
- Generates this block's contribution to the global stall so the FIFO never overflows.

---
 rtl/retire_stage.sv | 108 ++++++++++
 1 files changed

// File: rtl/retire_stage.sv
// Terminal stage of the address pipeline. It drops protected-window hits, raises a flush for each one, and queues the rest for the consumer.
// Latency 1 cycle from capture to out_valid. Consumer backpressure is absorbed by the FIFO; stall_out is registered and asserted early by STALL_MARGIN.
// Optional macro RETIRE_STATS_EN builds the saturating retired_count counter.
`ifndef ADDRESS_WIDTH
`define ADDRESS_WIDTH 16
`endif
`ifndef ID_WIDTH
`define ID_WIDTH 8
`endif

module retire_stage #(
   parameter int ADDR_W       = `ADDRESS_WIDTH,
   parameter int ID_W         = `ID_WIDTH,
   parameter int DEPTH        = 8,
   parameter int STALL_MARGIN = 3,
   parameter int CNT_W        = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] in_address,
   input  logic [ID_W-1:0]   in_id,
   input  logic              in_valid,
   input  logic              in_stall,
   input  logic              in_flush,
   input  logic [ID_W-1:0]   in_flush_id,
   input  logic [ADDR_W-1:0] prot_base,
   input  logic [ADDR_W-1:0] prot_limit,
   output logic [ADDR_W-1:0] out_address,
   output logic [ID_W-1:0]   out_id,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              stall_out,
   output logic              flush_req,
   output logic [ID_W-1:0]   flush_req_id,
   output logic [CNT_W-1:0]  violation_count,
   output logic              overflow,
   output logic [CNT_W-1:0]  retired_count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [AW:0] STALL_TH = (AW+1)'(DEPTH - STALL_MARGIN);

   logic [ADDR_W-1:0] mem_addr [DEPTH];
   logic [ID_W-1:0]   mem_id   [DEPTH];
   logic [AW-1:0]     rd_ptr, wr_ptr;
   logic [AW:0]       count, count_nxt;

   logic cand, squash, hit, viol, push_req, push, pop, full;

   always_comb begin
      cand      = in_valid && !in_stall;
      squash    = in_flush && (in_flush_id == in_id);
      // An inverted window (base > limit) can never satisfy both bounds.
      hit       = (in_address >= prot_base) && (in_address <= prot_limit);
      viol      = cand && !squash && hit;
      push_req  = cand && !squash && !hit;
      out_valid = (count != '0);
      full      = (count == FULL_CNT);
      pop       = out_valid && out_ready;
      push      = push_req && (!full || pop);
      count_nxt = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
   end

   assign out_address = out_valid ? mem_addr[rd_ptr] : '0;
   assign out_id      = out_valid ? mem_id[rd_ptr]   : '0;

   always_ff @(posedge clk) begin
      if (push) begin
         mem_addr[wr_ptr] <= in_address;
         mem_id[wr_ptr]   <= in_id;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr          <= '0;
         wr_ptr          <= '0;
         count           <= '0;
         stall_out       <= 1'b0;
         flush_req       <= 1'b0;
         flush_req_id    <= '0;
         violation_count <= '0;
         overflow        <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         count     <= count_nxt;
         stall_out <= (count_nxt >= STALL_TH);
         flush_req <= viol;
         if (viol) begin
            flush_req_id <= in_id;
            if (violation_count != '1) violation_count <= violation_count + CNT_W'(1);
         end
         if (push_req && full && !pop) overflow <= 1'b1;
      end
   end

`ifdef RETIRE_STATS_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                               retired_count <= '0;
      else if (pop && (retired_count != '1))   retired_count <= retired_count + CNT_W'(1);
   end
`else
   assign retired_count = '0;
`endif

endmodule
